// File: rtl/midi_note_tracker.sv
// MIDI note tracker: last-note-priority stack of held keys
// driving note, velocity, gate and retrigger for a mono voice.
module midi_note_tracker #(
  parameter int         DEPTH   = 8,
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b0,
  localparam int        CW      = $clog2(DEPTH + 1),
  localparam int        IW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_msg_valid,
  input  logic [23:0]   i_msg,
  output logic          o_busy,
  output logic          o_drop,
  output logic [6:0]    o_note,
  output logic [6:0]    o_velocity,
  output logic          o_gate,
  output logic          o_retrig,
  output logic [CW-1:0] o_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_SEARCH, S_SHIFT, S_PUSH, S_UPDATE
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE, EV_ON, EV_OFF, EV_ALL
  } ev_t;

  state_t        r_state;
  state_t        w_next;
  state_t        w_miss;
  ev_t           r_ev;
  ev_t           w_dec;
  logic [23:0]   r_msg;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic [6:0]    r_note [DEPTH];
  logic [6:0]    r_vel  [DEPTH];

  logic [6:0]    r_o_note;
  logic [6:0]    r_o_vel;
  logic          r_o_gate;
  logic          r_o_retrig;
  logic          r_o_drop;
  logic [CW-1:0] r_o_count;

  logic [7:0]    w_status;
  logic [6:0]    w_n;
  logic [6:0]    w_v;
  logic          w_empty;
  logic          w_full;
  logic          w_last;
  logic          w_hit;
  logic [IW-1:0] w_top;
  logic [IW-1:0] w_pos;

  assign w_status = r_msg[23:16];
  assign w_n      = r_msg[14:8];
  assign w_v      = r_msg[6:0];
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CW'(DEPTH));
  assign w_last   = (CW'(r_idx) == r_cnt - CW'(1));
  assign w_hit    = (r_note[r_idx] == w_n);
  assign w_top    = IW'(r_cnt - CW'(1));
  assign w_pos    = IW'(r_cnt);

  assign o_busy     = (r_state != S_IDLE);
  assign o_drop     = r_o_drop;
  assign o_note     = r_o_note;
  assign o_velocity = r_o_vel;
  assign o_gate     = r_o_gate;
  assign o_retrig   = r_o_retrig;
  assign o_count    = r_o_count;

  // Classify the latched message into a tracker event
  always_comb begin
    w_dec = EV_NONE;
    if (OMNI || w_status[3:0] == CHANNEL) begin
      unique case (1'b1)
        (w_status[7:4] == 4'h9 && w_v != '0):
          w_dec = EV_ON;
        (w_status[7:4] == 4'h8),
        (w_status[7:4] == 4'h9 && w_v == '0):
          w_dec = EV_OFF;
        (w_status[7:4] == 4'hB && w_n == 7'h7B):
          w_dec = EV_ALL;
        default:
          w_dec = EV_NONE;
      endcase
    end
  end

  // Next-state logic; w_miss is where a failed search goes
  always_comb begin
    w_next = r_state;
    w_miss = S_UPDATE;
    if (r_ev == EV_ON) begin
      w_miss = w_full ? S_SHIFT : S_PUSH;
    end
    case (r_state)
      S_IDLE:
        if (i_msg_valid) w_next = S_DECODE;
      S_DECODE:
        unique case (w_dec)
          EV_NONE: w_next = S_IDLE;
          EV_ALL:  w_next = S_UPDATE;
          default: w_next = S_SEARCH;
        endcase
      S_SEARCH:
        if (w_empty)     w_next = w_miss;
        else if (w_hit)  w_next = S_SHIFT;
        else if (w_last) w_next = w_miss;
      S_SHIFT:
        if (w_last) begin
          w_next = (r_ev == EV_ON) ? S_PUSH : S_UPDATE;
        end
      S_PUSH:
        w_next = S_UPDATE;
      S_UPDATE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Control datapath: message latch, index, count and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msg      <= '0;
      r_ev       <= EV_NONE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_o_note   <= '0;
      r_o_vel    <= '0;
      r_o_gate   <= 1'b0;
      r_o_retrig <= 1'b0;
      r_o_drop   <= 1'b0;
      r_o_count  <= '0;
    end else begin
      r_o_retrig <= 1'b0;
      r_o_drop   <= i_msg_valid && (r_state != S_IDLE);
      case (r_state)
        S_IDLE:
          if (i_msg_valid) r_msg <= i_msg;
        S_DECODE: begin
          r_ev  <= w_dec;
          r_idx <= '0;
          if (w_dec == EV_ALL) r_cnt <= '0;
        end
        S_SEARCH:
          if (w_empty)     r_idx <= '0;
          else if (w_hit)  r_idx <= r_idx;
          else if (w_last) r_idx <= '0;
          else             r_idx <= r_idx + IW'(1);
        S_SHIFT:
          if (w_last) r_cnt <= r_cnt - CW'(1);
          else        r_idx <= r_idx + IW'(1);
        S_PUSH:
          r_cnt <= r_cnt + CW'(1);
        S_UPDATE: begin
          r_o_count <= r_cnt;
          r_o_gate  <= !w_empty;
          if (!w_empty) begin
            r_o_note <= r_note[w_top];
            r_o_vel  <= r_vel[w_top];
          end
          r_o_retrig <= (r_ev == EV_ON) ||
                        (r_o_gate && !w_empty &&
                         r_note[w_top] != r_o_note);
        end
        default: ;
      endcase
    end
  end

  // Key stack storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (r_state == S_SHIFT && !w_last) begin
      r_note[r_idx] <= r_note[r_idx + IW'(1)];
      r_vel[r_idx]  <= r_vel[r_idx + IW'(1)];
    end else if (r_state == S_PUSH) begin
      r_note[w_pos] <= w_n;
      r_vel[w_pos]  <= w_v;
    end
  end

endmodule

// File: tb/tb_midi_note_tracker.sv
// Directed bench for midi_note_tracker (DEPTH=8, CHANNEL=0,
// OMNI=0) with hand-computed expected values.
module tb_midi_note_tracker;

  logic        clk;
  logic        rst_n;
  logic        i_msg_valid;
  logic [23:0] i_msg;
  logic        o_busy;
  logic        o_drop;
  logic [6:0]  o_note;
  logic [6:0]  o_velocity;
  logic        o_gate;
  logic        o_retrig;
  logic [3:0]  o_count;

  int n_chk;
  int n_err;

  midi_note_tracker #(
    .DEPTH(8), .CHANNEL(4'd0), .OMNI(1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_msg_valid(i_msg_valid),
    .i_msg      (i_msg),
    .o_busy     (o_busy),
    .o_drop     (o_drop),
    .o_note     (o_note),
    .o_velocity (o_velocity),
    .o_gate     (o_gate),
    .o_retrig   (o_retrig),
    .o_count    (o_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [23:0] m);
    @(negedge clk);
    i_msg_valid = 1'b1;
    i_msg       = m;
    @(negedge clk);
    i_msg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 64; k++) begin
      if (!o_busy) break;
      @(negedge clk);
    end
    if (o_busy) chk("idle_timeout", 32'(o_busy), 0);
  endtask

  task automatic send(input logic [23:0] m);
    put(m);
    wait_idle();
  endtask

  initial begin
    n_chk       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    i_msg_valid = 1'b0;
    i_msg       = '0;
    repeat (3) @(negedge clk);
    chk("rst_note",  32'(o_note), 0);
    chk("rst_vel",   32'(o_velocity), 0);
    chk("rst_gate",  32'(o_gate), 0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_busy",  32'(o_busy), 0);
    chk("rst_retr",  32'(o_retrig), 0);
    chk("rst_drop",  32'(o_drop), 0);
    rst_n = 1'b1;

    // First note on
    send(24'h903C64);
    chk("on1_note",  32'(o_note), 32'h3C);
    chk("on1_vel",   32'(o_velocity), 32'h64);
    chk("on1_gate",  32'(o_gate), 1);
    chk("on1_count", 32'(o_count), 1);
    chk("on1_retr",  32'(o_retrig), 1);
    @(negedge clk);
    chk("on1_retr0", 32'(o_retrig), 0);

    // Fall-back to older key
    send(24'h904064);
    send(24'h904364);
    chk("on3_count", 32'(o_count), 3);
    send(24'h804300);
    chk("fb_note",  32'(o_note), 32'h40);
    chk("fb_gate",  32'(o_gate), 1);
    chk("fb_retr",  32'(o_retrig), 1);
    chk("fb_count", 32'(o_count), 2);
    send(24'h904000);
    chk("fb2_note", 32'(o_note), 32'h3C);
    chk("fb2_retr", 32'(o_retrig), 1);
    send(24'h803C00);
    chk("rel_gate",  32'(o_gate), 0);
    chk("rel_note",  32'(o_note), 32'h3C);
    chk("rel_count", 32'(o_count), 0);
    chk("rel_retr",  32'(o_retrig), 0);

    // Overflow: 9 keys into 8 slots evicts the oldest
    for (int n = 8'h3C; n <= 8'h44; n++) send({8'h90, 8'(n), 8'h50});
    chk("ovf_count", 32'(o_count), 8);
    chk("ovf_note",  32'(o_note), 32'h44);
    for (int n = 8'h44; n >= 8'h3D; n--) begin
      send({8'h80, 8'(n), 8'h00});
      if (n > 8'h3D) begin
        chk("ovf_fb_note", 32'(o_note), 32'(n - 1));
        chk("ovf_fb_gate", 32'(o_gate), 1);
        chk("ovf_fb_retr", 32'(o_retrig), 1);
      end else begin
        chk("ovf_end_gate",  32'(o_gate), 0);
        chk("ovf_end_note",  32'(o_note), 32'h3D);
        chk("ovf_end_count", 32'(o_count), 0);
      end
    end
    send(24'h803C00);
    chk("unk_off_gate",  32'(o_gate), 0);
    chk("unk_off_count", 32'(o_count), 0);
    chk("unk_off_note",  32'(o_note), 32'h3D);

    // Re-strike moves key to top with new velocity
    send(24'h903C20);
    send(24'h904030);
    send(24'h903C7F);
    chk("rs_note",  32'(o_note), 32'h3C);
    chk("rs_vel",   32'(o_velocity), 32'h7F);
    chk("rs_count", 32'(o_count), 2);
    send(24'h803C00);
    chk("rs_off_note",  32'(o_note), 32'h40);
    chk("rs_off_vel",   32'(o_velocity), 32'h30);
    chk("rs_off_count", 32'(o_count), 1);
    send(24'h804000);
    chk("rs_clr_gate", 32'(o_gate), 0);

    // Ignored messages
    send(24'h913C64);
    chk("ign_ch_note",  32'(o_note), 32'h40);
    chk("ign_ch_gate",  32'(o_gate), 0);
    chk("ign_ch_busy",  32'(o_busy), 0);
    send(24'hE00040);
    chk("ign_pb_note",  32'(o_note), 32'h40);
    chk("ign_pb_count", 32'(o_count), 0);
    chk("ign_pb_retr",  32'(o_retrig), 0);

    // All notes off
    send(24'h903010);
    send(24'h903110);
    send(24'h903210);
    chk("ao_pre_count", 32'(o_count), 3);
    send(24'hB07B00);
    chk("ao_gate",  32'(o_gate), 0);
    chk("ao_count", 32'(o_count), 0);
    chk("ao_note",  32'(o_note), 32'h32);
    chk("ao_retr",  32'(o_retrig), 0);

    // Second valid while busy is dropped
    @(negedge clk);
    i_msg_valid = 1'b1;
    i_msg       = 24'h905011;
    @(negedge clk);
    i_msg_valid = 1'b0;
    @(negedge clk);
    i_msg_valid = 1'b1;
    i_msg       = 24'h905122;
    @(negedge clk);
    i_msg_valid = 1'b0;
    chk("drop_pulse", 32'(o_drop), 1);
    @(negedge clk);
    chk("drop_clear", 32'(o_drop), 0);
    wait_idle();
    chk("drop_note",  32'(o_note), 32'h50);
    chk("drop_vel",   32'(o_velocity), 32'h11);
    chk("drop_count", 32'(o_count), 1);

    // Reset in the middle of a shift
    send(24'h905111);
    send(24'h905211);
    chk("mid_pre_count", 32'(o_count), 3);
    put(24'h805000);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(o_busy), 0);
    chk("mid_rst_note",  32'(o_note), 0);
    chk("mid_rst_vel",   32'(o_velocity), 0);
    chk("mid_rst_gate",  32'(o_gate), 0);
    chk("mid_rst_count", 32'(o_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(24'h904566);
    chk("post_note",  32'(o_note), 32'h45);
    chk("post_count", 32'(o_count), 1);
    chk("post_gate",  32'(o_gate), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
